lvds_pattern_gen: RTL and testbench



---
 rtl/lvds_pattern_gen.sv | 172 +++++++++++++++++
 tb/tb_lvds_pattern_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_pattern_gen.sv
// Dual-pixel LVDS test-pattern generator: solid, gradient, colour bars, animated checker, border+cursor.
// Latency: 2 clocks from sampled (x,y) to o_color/o_color_even, identical for every mode.
// Backpressure: none; free-running, one dual-pixel result per clock, no stalls or handshake.
module lvds_pattern_gen #(
   parameter int X_W      = 12,
   parameter int Y_W      = 12,
   parameter int H_ACTIVE = 960,
   parameter int V_ACTIVE = 1200,
   parameter int BAR_W    = 240,
   parameter int CHK_LOG2 = 5,
   parameter int ANIM_BIT = 4,
   parameter int FC_W     = 16
) (
   input  logic            i_clk,
   input  logic            i_resetn,
   input  logic [X_W-1:0]  i_x,
   input  logic [Y_W-1:0]  i_y,
   input  logic [2:0]      i_mode,
   input  logic [23:0]     i_solid_color,
   output logic [23:0]     o_color,
   output logic [23:0]     o_color_even,
   output logic [FC_W-1:0] o_frame_cnt,
   output logic [2:0]      o_mode
);
   // Panel column is the dual-pixel column with the pixel-in-pair bit appended.
   localparam int CW = X_W + 1;
   localparam logic [X_W-1:0] H_ACT_X  = X_W'(H_ACTIVE);
   localparam logic [Y_W-1:0] V_ACT_Y  = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] V_LAST_Y = Y_W'(V_ACTIVE - 1);
   localparam logic [CW-1:0]  C_LAST   = CW'(2 * H_ACTIVE - 1);

   // Bar index by comparing against constant thresholds; saturates at 7.
   function automatic logic [2:0] bar_index(input logic [CW-1:0] c);
      logic [2:0] k;
      k = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (c >= CW'(i * BAR_W)) k = k + 3'd1;
      end
      return k;
   endfunction

   function automatic logic [23:0] bar_color(input logic [2:0] k);
      logic [23:0] rgb;
      case (k)
         3'd0:    rgb = 24'hFFFFFF;
         3'd1:    rgb = 24'hFFFF00;
         3'd2:    rgb = 24'h00FFFF;
         3'd3:    rgb = 24'h00FF00;
         3'd4:    rgb = 24'hFF00FF;
         3'd5:    rgb = 24'hFF0000;
         3'd6:    rgb = 24'h0000FF;
         default: rgb = 24'h000000;
      endcase
      return rgb;
   endfunction

   // Colour of one active panel pixel under the latched frame state.
   function automatic logic [23:0] pix(
      input logic [CW-1:0]  c,
      input logic [Y_W-1:0] y,
      input logic [2:0]     mode,
      input logic [23:0]    solid,
      input logic [CW-1:0]  cursor,
      input logic [7:0]     scroll,
      input logic           anim
   );
      logic [23:0] rgb;
      logic [7:0]  red;
      rgb = 24'h000000;
      red = c[7:0] + scroll;
      case (mode)
         3'd0: rgb = solid;
         3'd1: rgb = {red, y[7:0], 8'h00};
         3'd2: rgb = bar_color(bar_index(c));
         3'd3: rgb = (c[CHK_LOG2] ^ y[CHK_LOG2] ^ anim) ? 24'hFFFFFF : 24'h000000;
         3'd4: begin
            // Border has priority over the cursor column.
            if (c == '0 || c == C_LAST || y == '0 || y == V_LAST_Y) rgb = 24'hFFFFFF;
            else if (c == cursor)                                   rgb = 24'hFF0000;
            else                                                     rgb = 24'h00FF00;
         end
         default: rgb = 24'h000000;
      endcase
      return rgb;
   endfunction

   logic [X_W-1:0]  x_q, x_d;
   logic [Y_W-1:0]  y_q, y_d;
   logic [23:0]     solid_q, solid_d;
   logic            prev_zero_q, prev_zero_d;
   logic [2:0]      mode_q, mode_d;
   logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CW-1:0]   cursor_q, cursor_d;
   logic [7:0]      scroll_q, scroll_d;
   logic [23:0]     color_q, color_d;
   logic [23:0]     color_even_q, color_even_d;
   logic            fs;
   logic            active;

   // Stage 1: capture coordinates/solid colour, detect frame start and advance frame state on it.
   always_comb begin
      fs          = (i_x == '0) && (i_y == '0) && !prev_zero_q;
      x_d         = i_x;
      y_d         = i_y;
      solid_d     = i_solid_color;
      prev_zero_d = (i_x == '0) && (i_y == '0);
      mode_d      = mode_q;
      frame_cnt_d = frame_cnt_q;
      cursor_d    = cursor_q;
      scroll_d    = scroll_q;
      if (fs) begin
         mode_d      = i_mode;
         frame_cnt_d = frame_cnt_q + FC_W'(1);
         cursor_d    = (cursor_q == C_LAST) ? '0 : cursor_q + CW'(1);
         scroll_d    = scroll_q + 8'd1;
      end
   end

   // Stage 1 and frame-state registers; a cleared prev_zero flag stands for a "previous" of (1,0),
   // so a reset released while sitting at (0,0) still produces a frame start.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         x_q         <= '0;
         y_q         <= '0;
         solid_q     <= '0;
         prev_zero_q <= 1'b0;
         mode_q      <= '0;
         frame_cnt_q <= '0;
         cursor_q    <= '0;
         scroll_q    <= '0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         solid_q     <= solid_d;
         prev_zero_q <= prev_zero_d;
         mode_q      <= mode_d;
         frame_cnt_q <= frame_cnt_d;
         cursor_q    <= cursor_d;
         scroll_q    <= scroll_d;
      end
   end

   // Stage 2: pattern mux for both pixels of the pair; anything outside the active area is black.
   always_comb begin
      active       = (x_q < H_ACT_X) && (y_q < V_ACT_Y);
      color_d      = 24'h000000;
      color_even_d = 24'h000000;
      if (active) begin
         color_d      = pix({x_q, 1'b0}, y_q, mode_q, solid_q, cursor_q, scroll_q,
                            frame_cnt_q[ANIM_BIT]);
         color_even_d = pix({x_q, 1'b1}, y_q, mode_q, solid_q, cursor_q, scroll_q,
                            frame_cnt_q[ANIM_BIT]);
      end
   end

   // Stage 2 output registers.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         color_q      <= '0;
         color_even_q <= '0;
      end else begin
         color_q      <= color_d;
         color_even_q <= color_even_d;
      end
   end

   assign o_color      = color_q;
   assign o_color_even = color_even_q;
   assign o_frame_cnt  = frame_cnt_q;
   assign o_mode       = mode_q;

endmodule

// File: tb/tb_lvds_pattern_gen.sv
// Bench for lvds_pattern_gen: directed scenarios plus randomized coordinates/modes against a reference model.
// Latency: model result for an input is due on the outputs one edge after the edge that samples it.
// Backpressure: none in the DUT; the bench drives one coordinate pair per clock.
module tb_lvds_pattern_gen;
   localparam int X_W      = 12;
   localparam int Y_W      = 12;
   localparam int H_ACTIVE = 960;
   localparam int V_ACTIVE = 1200;
   localparam int BAR_W    = 240;
   localparam int CHK_LOG2 = 5;
   localparam int ANIM_BIT = 4;
   localparam int FC_W     = 16;

   logic            i_clk = 1'b0;
   logic            i_resetn = 1'b1;
   logic [X_W-1:0]  i_x = '0;
   logic [Y_W-1:0]  i_y = '0;
   logic [2:0]      i_mode = '0;
   logic [23:0]     i_solid_color = '0;
   logic [23:0]     o_color;
   logic [23:0]     o_color_even;
   logic [FC_W-1:0] o_frame_cnt;
   logic [2:0]      o_mode;

   always #5 i_clk = ~i_clk;

   lvds_pattern_gen #(
      .X_W(X_W), .Y_W(Y_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BAR_W(BAR_W),
      .CHK_LOG2(CHK_LOG2), .ANIM_BIT(ANIM_BIT), .FC_W(FC_W)
   ) dut (
      .i_clk(i_clk), .i_resetn(i_resetn), .i_x(i_x), .i_y(i_y), .i_mode(i_mode),
      .i_solid_color(i_solid_color), .o_color(o_color), .o_color_even(o_color_even),
      .o_frame_cnt(o_frame_cnt), .o_mode(o_mode)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: frame-level state as plain integers.
   int m_mode, m_fc, m_cursor, m_scroll, m_px, m_py;
   logic [23:0] pend_c, pend_e, exp_c, exp_e;
   int exp_fc, exp_mode;

   function automatic logic [23:0] ref_pix(int c, int y, int mode, logic [23:0] solid,
                                           int cursor, int scroll, int fc);
      int k;
      if (mode == 0) return solid;
      if (mode == 1) return {8'((c + scroll) % 256), 8'(y % 256), 8'h00};
      if (mode == 2) begin
         k = c / BAR_W;
         if (k > 7) k = 7;
         case (k)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
         endcase
      end
      if (mode == 3)
         return ((((c / (1 << CHK_LOG2)) + (y / (1 << CHK_LOG2)) + (fc / (1 << ANIM_BIT))) % 2) == 1)
                ? 24'hFFFFFF : 24'h000000;
      if (mode == 4) begin
         if (c == 0 || c == 2 * H_ACTIVE - 1 || y == 0 || y == V_ACTIVE - 1) return 24'hFFFFFF;
         if (c == cursor) return 24'hFF0000;
         return 24'h00FF00;
      end
      return 24'h000000;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_fc = 0; m_cursor = 0; m_scroll = 0;
      m_px = 1; m_py = 0;
      pend_c = '0; pend_e = '0; exp_c = '0; exp_e = '0;
      exp_fc = 0; exp_mode = 0;
   endtask

   // One clock: model reacts to the pair sampled at this edge; exp_* then hold what the outputs show now.
   task automatic tick();
      int x, y;
      logic [23:0] nc, ne;
      @(posedge i_clk);
      x = int'(i_x);
      y = int'(i_y);
      nc = '0;
      ne = '0;
      if (i_resetn) begin
         if (x == 0 && y == 0 && !(m_px == 0 && m_py == 0)) begin
            m_mode   = int'(i_mode);
            m_fc     = (m_fc + 1) % (1 << FC_W);
            m_cursor = (m_cursor + 1) % (2 * H_ACTIVE);
            m_scroll = (m_scroll + 1) % 256;
         end
         m_px = x;
         m_py = y;
         if (x < H_ACTIVE && y < V_ACTIVE) begin
            nc = ref_pix(2 * x,     y, m_mode, i_solid_color, m_cursor, m_scroll, m_fc);
            ne = ref_pix(2 * x + 1, y, m_mode, i_solid_color, m_cursor, m_scroll, m_fc);
         end
      end
      #1;
      exp_c = pend_c; exp_e = pend_e;
      pend_c = nc;    pend_e = ne;
      exp_fc = m_fc;  exp_mode = m_mode;
   endtask

   task automatic drive(int x, int y);
      i_x = X_W'(x);
      i_y = Y_W'(y);
   endtask

   // Synthetic frame start: leave (0,0), then return to it with the requested mode.
   task automatic frame_pulse(int mode);
      i_mode = 3'(mode);
      drive(1, 0); tick();
      drive(0, 0); tick();
   endtask

   task automatic test_reset();
      logic [23:0] solid;
      solid = 24'($urandom);
      i_solid_color = solid;
      i_mode = 3'd2;
      drive(7, 3);
      #2 i_resetn = 1'b0;
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      checks++; if (o_color !== 24'h0 || o_color_even !== 24'h0) begin errors++;
         $display("FAIL reset_colors got %h/%h want 000000/000000", o_color, o_color_even); end
      checks++; if (o_frame_cnt !== '0 || o_mode !== 3'd0) begin errors++;
         $display("FAIL reset_state got fc=%0d mode=%0d want 0/0", o_frame_cnt, o_mode); end
      i_resetn = 1'b1;
      tick();
      checks++; if (o_color !== 24'h0 || o_color_even !== 24'h0) begin errors++;
         $display("FAIL first_cycle_after_release got %h/%h want 0/0", o_color, o_color_even); end
      drive(8, 3);
      tick();
      checks++; if (o_color !== solid || o_color_even !== solid || o_color !== exp_c) begin errors++;
         $display("FAIL solid_before_fs got %h/%h want %h", o_color, o_color_even, solid); end
      checks++; if (o_mode !== 3'd0) begin errors++;
         $display("FAIL mode_before_fs got %0d want 0", o_mode); end
      drive(0, 0);
      tick();
      checks++; if (o_mode !== 3'd2 || o_frame_cnt !== 16'd1) begin errors++;
         $display("FAIL first_fs got mode=%0d fc=%0d want 2/1", o_mode, o_frame_cnt); end
   endtask

   task automatic test_bars();
      int          xs   [7] = '{0, 119, 120, 239, 240, 479, 959};
      logic [23:0] want [7] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                                24'h00FFFF, 24'h00FF00, 24'h000000};
      for (int i = 0; i < 7; i++) begin
         drive(xs[i], 10);
         tick(); tick();
         checks++; if (o_color !== want[i] || o_color_even !== want[i] || o_color !== exp_c) begin
            errors++;
            $display("FAIL bars x=%0d got %h/%h want %h/%h", xs[i], o_color, o_color_even, want[i], want[i]);
         end
      end
   endtask

   task automatic test_border();
      int          xs [5] = '{0, 1, 959, 500, 1000};
      int          ys [5] = '{10, 10, 10, 1199, 1199};
      logic [23:0] wc [5] = '{24'hFFFFFF, 24'h00FF00, 24'h00FF00, 24'hFFFFFF, 24'h000000};
      logic [23:0] we [5] = '{24'h00FF00, 24'hFF0000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
      for (int n = 0; n < 10 && m_cursor != 3; n++) frame_pulse(4);
      checks++; if (o_mode !== 3'd4 || o_frame_cnt !== 16'd3) begin errors++;
         $display("FAIL border_setup got mode=%0d fc=%0d want 4/3", o_mode, o_frame_cnt); end
      for (int i = 0; i < 5; i++) begin
         drive(xs[i], ys[i]);
         tick(); tick();
         checks++; if (o_color !== wc[i] || o_color_even !== we[i] || o_color_even !== exp_e) begin
            errors++;
            $display("FAIL border x=%0d y=%0d got %h/%h want %h/%h",
                     xs[i], ys[i], o_color, o_color_even, wc[i], we[i]);
         end
      end
   endtask

   task automatic test_mode_change_checker();
      frame_pulse(2);
      i_mode = 3'd3;
      for (int i = 0; i < 3; i++) begin
         drive(100 + i, 20);
         tick();
         checks++; if (o_mode !== 3'd2) begin errors++;
            $display("FAIL mode_held_midframe got %0d want 2", o_mode); end
      end
      for (int n = 0; n < 40 && m_fc != 16; n++) frame_pulse(3);
      checks++; if (o_mode !== 3'd3 || o_frame_cnt !== 16'd16) begin errors++;
         $display("FAIL checker_setup got mode=%0d fc=%0d want 3/16", o_mode, o_frame_cnt); end
      drive(16, 0); tick(); tick();
      checks++; if (o_color !== 24'h000000 || o_color_even !== 24'h000000 || o_color !== exp_c) begin
         errors++;
         $display("FAIL checker_f16 got %h/%h want 000000/000000", o_color, o_color_even); end
      for (int n = 0; n < 40 && m_fc != 32; n++) frame_pulse(3);
      drive(16, 0); tick(); tick();
      checks++; if (o_color !== 24'hFFFFFF || o_color_even !== 24'hFFFFFF || o_color !== exp_c) begin
         errors++;
         $display("FAIL checker_f32 got %h/%h want FFFFFF/FFFFFF", o_color, o_color_even); end
   endtask

   task automatic test_gradient();
      #2 i_resetn = 1'b0;
      model_reset();
      i_mode = 3'd1;
      drive(0, 0);
      tick();
      i_resetn = 1'b1;
      tick();
      checks++; if (o_frame_cnt !== 16'd1 || o_mode !== 3'd1) begin errors++;
         $display("FAIL fs_at_release got fc=%0d mode=%0d want 1/1", o_frame_cnt, o_mode); end
      for (int n = 0; n < 4; n++) frame_pulse(1);
      drive(0, 7); tick(); tick();
      checks++; if (o_color !== 24'h050700 || o_color_even !== 24'h060700 || o_color !== exp_c) begin
         errors++;
         $display("FAIL gradient got %h/%h want 050700/060700", o_color, o_color_even); end
      drive(1000, 7); tick(); tick();
      checks++; if (o_color !== 24'h0 || o_color_even !== 24'h0) begin errors++;
         $display("FAIL gradient_offscreen got %h/%h want 0/0", o_color, o_color_even); end
   endtask

   task automatic test_random();
      int x, y;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) i_mode = 3'($urandom_range(0, 7));
         i_solid_color = 24'($urandom);
         case ($urandom_range(0, 9))
            0:       begin x = 0; y = 0; end
            1:       begin x = $urandom_range(955, 965); y = $urandom_range(0, 3); end
            2:       begin x = $urandom_range(0, 3); y = $urandom_range(1196, 1203); end
            3:       begin x = $urandom_range(0, 4095); y = $urandom_range(0, 4095); end
            default: begin x = $urandom_range(0, 1000); y = $urandom_range(0, 1250); end
         endcase
         drive(x, y);
         tick();
         checks++; if (o_color !== exp_c) begin errors++;
            $display("FAIL rand_color[%0d] got %h want %h", i, o_color, exp_c); end
         checks++; if (o_color_even !== exp_e) begin errors++;
            $display("FAIL rand_color_even[%0d] got %h want %h", i, o_color_even, exp_e); end
         checks++; if (int'(o_frame_cnt) !== exp_fc) begin errors++;
            $display("FAIL rand_frame_cnt[%0d] got %0d want %0d", i, o_frame_cnt, exp_fc); end
         checks++; if (int'(o_mode) !== exp_mode) begin errors++;
            $display("FAIL rand_mode[%0d] got %0d want %0d", i, o_mode, exp_mode); end
      end
   endtask

   task automatic test_reset_midframe();
      for (int n = 0; n < 300 && m_fc != 100; n++) frame_pulse(4);
      checks++; if (o_frame_cnt !== 16'd100 || o_mode !== 3'd4) begin errors++;
         $display("FAIL midreset_setup got fc=%0d mode=%0d want 100/4", o_frame_cnt, o_mode); end
      drive(300, 50); tick(); tick();
      checks++; if (o_color !== 24'h00FF00 || o_color_even !== 24'h00FF00) begin errors++;
         $display("FAIL midreset_before got %h/%h want 00FF00/00FF00", o_color, o_color_even); end
      #2 i_resetn = 1'b0;
      #1;
      checks++; if (o_color !== 24'h0 || o_color_even !== 24'h0 || o_frame_cnt !== '0 || o_mode !== 3'd0) begin
         errors++;
         $display("FAIL async_reset got %h/%h fc=%0d mode=%0d want 0/0/0/0",
                  o_color, o_color_even, o_frame_cnt, o_mode); end
      model_reset();
      tick();
      i_resetn = 1'b1;
      drive(0, 10); tick();
      drive(0, 0);  tick();
      checks++; if (o_frame_cnt !== 16'd1 || o_mode !== 3'd4) begin errors++;
         $display("FAIL fs_after_midreset got fc=%0d mode=%0d want 1/4", o_frame_cnt, o_mode); end
      drive(0, 10); tick(); tick();
      checks++; if (o_color !== 24'hFFFFFF || o_color_even !== 24'hFF0000 || o_color_even !== exp_e) begin
         errors++;
         $display("FAIL cursor_after_midreset got %h/%h want FFFFFF/FF0000", o_color, o_color_even); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_bars();
      test_border();
      test_mode_change_checker();
      test_gradient();
      test_random();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
